vpu_reduction_issuer: RTL

//  Front-end sequencer for the VPU reduction engine. Accepts one full-vector FSUM/FMAX request.

---
 rtl/vpu_reduction_issuer_pkg.sv | 31 +++
 rtl/vpu_reduction_issuer_if.sv | 40 ++++
 rtl/vpu_reduction_issuer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/vpu_reduction_issuer_pkg.sv
// Shared types and constants for the VPU reduction issuer: request opcodes, vector geometry
// and the issuer FSM state encoding.
package vpu_reduction_issuer_pkg;

  localparam int unsigned ELEM_PER_DIM_CNT = 32;
  localparam int unsigned EXEC_CNT         = 2;
  localparam int unsigned OPERAND_WIDTH    = 16;

  typedef enum logic [2:0] {
    VPU_H2D_REQ_OPCODE_NOP   = 3'd0,
    VPU_H2D_REQ_OPCODE_LOAD  = 3'd1,
    VPU_H2D_REQ_OPCODE_STORE = 3'd2,
    VPU_H2D_REQ_OPCODE_FADD  = 3'd3,
    VPU_H2D_REQ_OPCODE_FMUL  = 3'd4,
    VPU_H2D_REQ_OPCODE_FSUM  = 3'd5,
    VPU_H2D_REQ_OPCODE_FMAX  = 3'd6,
    VPU_H2D_REQ_OPCODE_FMIN  = 3'd7
  } vpu_h2d_req_opcode_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } vpu_red_issue_state_t;

  function automatic logic is_red_opcode(vpu_h2d_req_opcode_t op);
    return (op == VPU_H2D_REQ_OPCODE_FSUM) || (op == VPU_H2D_REQ_OPCODE_FMAX);
  endfunction

endpackage

// File: rtl/vpu_reduction_issuer_if.sv
// Request, engine and response signal bundle for the reduction issuer. The issuer side uses
// the master modport; the decoder/engine environment uses the slave modport.
interface vpu_reduction_issuer_if
  import vpu_reduction_issuer_pkg::*;
#(
  parameter int unsigned ElemCnt      = ELEM_PER_DIM_CNT,
  parameter int unsigned ExecCnt      = EXEC_CNT,
  parameter int unsigned OperandWidth = OPERAND_WIDTH
) ();

  localparam int unsigned BeatW = ElemCnt / ExecCnt * OperandWidth;

  logic                              req_valid;
  logic                              req_ready;
  vpu_h2d_req_opcode_t               req_opcode;
  logic [ElemCnt*OperandWidth-1:0]   req_vec;

  logic                              start;
  vpu_h2d_req_opcode_t               opcode;
  logic                              is_sum;
  logic [BeatW-1:0]                  operand;
  logic                              done;
  logic [BeatW-1:0]                  dout;

  logic                              resp_valid;
  logic                              resp_ready;
  logic [OperandWidth-1:0]           resp_data;
  logic                              resp_err;

  modport master (
    input  req_valid, req_opcode, req_vec, done, dout, resp_ready,
    output req_ready, start, opcode, is_sum, operand, resp_valid, resp_data, resp_err
  );

  modport slave (
    output req_valid, req_opcode, req_vec, done, dout, resp_ready,
    input  req_ready, start, opcode, is_sum, operand, resp_valid, resp_data, resp_err
  );

endinterface

// File: rtl/vpu_reduction_issuer.sv
// Reduction front-end: slices one FSUM/FMAX vector into back-to-back engine beats, waits for
// done and returns lane 0 as the scalar result. Optional WAIT watchdog: VPU_RED_ISSUE_TIMEOUT_EN.
module vpu_reduction_issuer
  import vpu_reduction_issuer_pkg::*;
#(
  parameter int unsigned ElemCnt       = ELEM_PER_DIM_CNT,
  parameter int unsigned ExecCnt       = EXEC_CNT,
  parameter int unsigned OperandWidth  = OPERAND_WIDTH
`ifdef VPU_RED_ISSUE_TIMEOUT_EN
  ,
  parameter int unsigned TimeoutCycles = 255
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  vpu_reduction_issuer_if.master bus_io
);

  localparam int unsigned Dw    = ElemCnt / ExecCnt * OperandWidth;
  localparam int unsigned BeatW = $clog2(ExecCnt) + 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(ExecCnt - 1);

  vpu_red_issue_state_t            state_q, state_d;
  logic [BeatW-1:0]                beat_q, beat_d;
  logic [ElemCnt*OperandWidth-1:0] vec_q, vec_d;
  vpu_h2d_req_opcode_t             opcode_q, opcode_d;
  logic                            is_sum_q, is_sum_d;
  logic [OperandWidth-1:0]         data_q, data_d;
  logic                            err_q, err_d;
  logic                            accept;
  logic                            timeout;
  logic                            unused_dout;

  // Only lane 0 of the broadcast result is meaningful.
  assign unused_dout = ^bus_io.dout[Dw-1:OperandWidth];

`ifdef VPU_RED_ISSUE_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  assign timeout = (wait_cnt_q == CntW'(TimeoutCycles - 1));
`else
  assign timeout = 1'b0;
`endif

  assign bus_io.req_ready = (state_q == StIdle) & rst_n;
  assign accept           = bus_io.req_valid & bus_io.req_ready;

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    vec_d    = vec_q;
    opcode_d = opcode_q;
    is_sum_d = is_sum_q;
    data_d   = data_q;
    err_d    = err_q;
`ifdef VPU_RED_ISSUE_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          vec_d    = bus_io.req_vec;
          opcode_d = bus_io.req_opcode;
          is_sum_d = (bus_io.req_opcode == VPU_H2D_REQ_OPCODE_FSUM);
          beat_d   = '0;
          if (is_red_opcode(bus_io.req_opcode)) begin
            state_d = StIssue;
          end else begin
            state_d = StResp;
            err_d   = 1'b1;
            data_d  = '0;
          end
        end
      end
      StIssue: begin
        beat_d = beat_q + BeatW'(1);
        if (beat_q == LastBeat) begin
          state_d = StWait;
`ifdef VPU_RED_ISSUE_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end
      end
      StWait: begin
        if (bus_io.done) begin
          data_d  = bus_io.dout[OperandWidth-1:0];
          err_d   = 1'b0;
          state_d = StResp;
        end else if (timeout) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end
`ifdef VPU_RED_ISSUE_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q + CntW'(1);
`endif
      end
      StResp: begin
        if (bus_io.resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      beat_q   <= '0;
      vec_q    <= '0;
      opcode_q <= VPU_H2D_REQ_OPCODE_FSUM;
      is_sum_q <= 1'b0;
      data_q   <= '0;
      err_q    <= 1'b0;
`ifdef VPU_RED_ISSUE_TIMEOUT_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      vec_q    <= vec_d;
      opcode_q <= opcode_d;
      is_sum_q <= is_sum_d;
      data_q   <= data_d;
      err_q    <= err_d;
`ifdef VPU_RED_ISSUE_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  always_comb begin
    bus_io.start   = (state_q == StIssue);
    bus_io.operand = '0;
    if (state_q == StIssue) begin
      bus_io.operand = vec_q[beat_q*Dw +: Dw];
    end
  end

  assign bus_io.opcode     = opcode_q;
  assign bus_io.is_sum     = is_sum_q;
  assign bus_io.resp_valid = (state_q == StResp);
  assign bus_io.resp_data  = data_q;
  assign bus_io.resp_err   = err_q;

endmodule
